// File: rtl/div_issue_pkg.sv
// div_issue_pkg: func3 encodings, FSM states and RV32M divide
// special-case constants shared by the divide issue block.
package div_issue_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [31:0] DIV_MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic       neg_q;
        logic       neg_r;
        logic       is_rem;
        logic [4:0] rd;
    } div_ctl_t;

    function automatic logic f3_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            INST_DIV, INST_REM:   r = 1'b1;
            INST_DIVU, INST_REMU: r = 1'b0;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        logic r;
        case (f3)
            INST_REM, INST_REMU: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: passes a value through or returns its two's
// complement; used for operand magnitudes and result correction.
module div_sign_fix (
    input  logic [31:0] val,
    input  logic        neg,
    output logic [31:0] res
);

    assign res = neg ? (~val + 32'd1) : val;

endmodule

// File: rtl/div_issue.sv
// div_issue: RV32M DIV/DIVU/REM/REMU issue, special cases and
// result formatting. Optional result cache: DIV_RESULT_CACHE_EN.
module div_issue
    import div_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_func3,
    input  logic        ex_muldiv,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        stall_req,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_abort,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    input  logic        div_done,
    output logic        wd_en,
    output logic [4:0]  wd_addr,
    output logic [31:0] wd_data
);

    div_state_e  state_q;
    div_state_e  state_d;
    div_ctl_t    ctl_q;
    logic        accept;
    logic        take_res;
    logic        acc_sgn;
    logic        is_div0;
    logic        is_ovf;
    logic        hit;
    logic        to_done;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] quot_q;
    logic [31:0] rem_q;

    assign acc_sgn = f3_signed(ex_func3);
    assign is_div0 = (ex_op2 == 32'd0);
    assign is_ovf  = acc_sgn
                   & (ex_op1 == DIV_MIN_NEG)
                   & (ex_op2 == DIV_ALL_ONES);
    assign to_done = is_div0 | is_ovf | hit;

    div_sign_fix u_op1_fix (
        .val (ex_op1),
        .neg (acc_sgn & ex_op1[31]),
        .res (op1_mag)
    );

    div_sign_fix u_op2_fix (
        .val (ex_op2),
        .neg (acc_sgn & ex_op2[31]),
        .res (op2_mag)
    );

    div_sign_fix u_quot_fix (
        .val (div_quot),
        .neg (ctl_q.neg_q),
        .res (quot_fix)
    );

    div_sign_fix u_rem_fix (
        .val (div_rem),
        .neg (ctl_q.neg_r),
        .res (rem_fix)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic        c_valid;
    logic        c_sgn;
    logic [31:0] c_op1;
    logic [31:0] c_op2;
    logic [31:0] c_quot;
    logic [31:0] c_rem;
    logic        sgn_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;

    assign hit = c_valid
               & (c_sgn == acc_sgn)
               & (c_op1 == ex_op1)
               & (c_op2 == ex_op2);

    // Raw operand tag of the in-flight op, used to fill the cache
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            sgn_q <= acc_sgn;
            op1_q <= ex_op1;
            op2_q <= ex_op2;
        end
    end

    // Last divider result; flush leaves it valid, only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            c_op1   <= '0;
            c_op2   <= '0;
            c_quot  <= '0;
            c_rem   <= '0;
        end else if (take_res) begin
            c_valid <= 1'b1;
            c_sgn   <= sgn_q;
            c_op1   <= op1_q;
            c_op2   <= op2_q;
            c_quot  <= quot_fix;
            c_rem   <= rem_fix;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept, stall and abort; rst masks all strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        take_res  = 1'b0;
        stall_req = 1'b0;
        div_abort = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ex_valid && ex_muldiv && ex_func3[2] && !flush) begin
                        accept    = 1'b1;
                        stall_req = 1'b1;
                        state_d   = to_done ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    stall_req = 1'b1;
                    if (flush) begin
                        div_abort = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (div_done) begin
                        take_res = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Capture operands/control at accept and the formatted result
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q        <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
        end else begin
            div_start <= accept & ~to_done;
            if (accept) begin
                ctl_q.neg_q  <= acc_sgn & (ex_op1[31] ^ ex_op2[31]);
                ctl_q.neg_r  <= acc_sgn & ex_op1[31];
                ctl_q.is_rem <= f3_is_rem(ex_func3);
                ctl_q.rd     <= ex_rd;
                div_dividend <= op1_mag;
                div_divisor  <= op2_mag;
            end
            if (accept && is_div0) begin
                quot_q <= DIV_ALL_ONES;
                rem_q  <= ex_op1;
            end else if (accept && is_ovf) begin
                quot_q <= DIV_MIN_NEG;
                rem_q  <= '0;
`ifdef DIV_RESULT_CACHE_EN
            end else if (accept && hit) begin
                quot_q <= c_quot;
                rem_q  <= c_rem;
`endif
            end else if (take_res) begin
                quot_q <= quot_fix;
                rem_q  <= rem_fix;
            end
        end
    end

    assign wd_en   = (state_q == ST_DONE) && (ctl_q.rd != 5'd0);
    assign wd_addr = ctl_q.rd;
    assign wd_data = ctl_q.is_rem ? rem_q : quot_q;

endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: directed bench for div_issue with a cycle-indexed
// expectation model derived from RV32M arithmetic and issue timing.
module tb_div_issue;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;
    localparam int NC = 4096;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_func3 = 3'b000;
    logic        ex_muldiv = 1'b0;
    logic [31:0] ex_op1 = '0;
    logic [31:0] ex_op2 = '0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_abort;
    logic [31:0] div_quot = '0;
    logic [31:0] div_rem = '0;
    logic        div_done = 1'b0;
    logic        wd_en;
    logic [4:0]  wd_addr;
    logic [31:0] wd_data;

    div_issue dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_func3     (ex_func3),
        .ex_muldiv    (ex_muldiv),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .stall_req    (stall_req),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_abort    (div_abort),
        .div_quot     (div_quot),
        .div_rem      (div_rem),
        .div_done     (div_done),
        .wd_en        (wd_en),
        .wd_addr      (wd_addr),
        .wd_data      (wd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          exp_stall [NC];
    bit          exp_start [NC];
    bit          exp_abort [NC];
    bit          exp_wr    [NC];
    logic [4:0]  exp_addr  [NC];
    logic [31:0] exp_data  [NC];
    logic [31:0] exp_dvd   [NC];
    logic [31:0] exp_dvs   [NC];

    int total = 0;
    int bad = 0;
    logic [31:0] last_dvd = '0;
    logic [31:0] last_dvs = '0;

    bit          m_cv = 1'b0;
    logic        m_cs = 1'b0;
    logic [31:0] m_c1 = '0;
    logic [31:0] m_c2 = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void model_qr(input logic sg,
                                     input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] q,
                                     output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Per-cycle compare against the expectation tables
    always @(negedge clk) begin
        if (!rst && cyc < NC) begin
            chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall[cyc]});
            chk("div_start", {31'd0, div_start}, {31'd0, exp_start[cyc]});
            chk("div_abort", {31'd0, div_abort}, {31'd0, exp_abort[cyc]});
            chk("wd_en", {31'd0, wd_en},
                {31'd0, exp_wr[cyc] && exp_addr[cyc] != 5'd0});
            if (exp_wr[cyc] && exp_addr[cyc] != 5'd0) begin
                chk("wd_addr", {27'd0, wd_addr}, {27'd0, exp_addr[cyc]});
                chk("wd_data", wd_data, exp_data[cyc]);
            end
            if (exp_start[cyc]) begin
                chk("div_dividend", div_dividend, exp_dvd[cyc]);
                chk("div_divisor", div_divisor, exp_dvs[cyc]);
            end
            if (div_start) begin
                last_dvd = div_dividend;
                last_dvs = div_divisor;
            end
        end
    end

    // One instruction; returns in its DONE cycle (or after flush/rst).
    // flush_k / rst_k: WAIT cycle index to flush / reset, -1 for none.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input int lat, input int flush_k,
                          input int rst_k);
        int t;
        logic sg, spc, hit;
        logic [31:0] q, r, ma, mb;
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ex_muldiv = 1'b1;
        ex_func3 = f3;
        ex_op1 = a;
        ex_op2 = b;
        ex_rd = rd;
        t = cyc;
        sg = ~f3[0];
        model_qr(sg, a, b, q, r);
        spc = (b == 32'd0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit = CACHE_ON && m_cv && m_cs == sg && m_c1 == a && m_c2 == b;
        exp_stall[t] = 1'b1;
        if (spc || hit) begin
            exp_wr[t+1] = 1'b1;
            exp_addr[t+1] = rd;
            exp_data[t+1] = f3[1] ? r : q;
            @(posedge clk); #1;
            ex_valid = 1'b0;
            return;
        end
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        exp_start[t+1] = 1'b1;
        exp_dvd[t+1] = ma;
        exp_dvs[t+1] = mb;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            if (k == rst_k) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                m_cv = 1'b0;
                return;
            end
            exp_stall[t+1+k] = 1'b1;
            if (k == flush_k) begin
                flush = 1'b1;
                exp_abort[t+1+k] = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                end
                div_done = 1'b1;
                div_quot = ma / mb;
                div_rem = ma % mb;
                @(posedge clk); #1;
                div_done = 1'b0;
                return;
            end
            if (k == lat) begin
                div_done = 1'b1;
                div_quot = ma / mb;
                div_rem = ma % mb;
            end
            @(posedge clk); #1;
        end
        div_done = 1'b0;
        exp_wr[t+2+lat] = 1'b1;
        exp_addr[t+2+lat] = rd;
        exp_data[t+2+lat] = f3[1] ? r : q;
        m_cv = 1'b1;
        m_cs = sg;
        m_c1 = a;
        m_c2 = b;
    endtask

    task automatic pin(input string n, input logic [31:0] v);
        chk({n, "_en"}, {31'd0, wd_en}, 32'd1);
        chk(n, wd_data, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            exp_addr[i] = '0;
            exp_data[i] = '0;
            exp_dvd[i] = '0;
            exp_dvs[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_start", {31'd0, div_start}, 32'd0);
        chk("rst_abort", {31'd0, div_abort}, 32'd0);
        chk("rst_wd_en", {31'd0, wd_en}, 32'd0);
        chk("rst_wd_addr", {27'd0, wd_addr}, 32'd0);
        chk("rst_wd_data", wd_data, 32'd0);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_divisor", div_divisor, 32'd0);

        // Non-divide M op and non-M divide encoding are ignored
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_func3 = 3'b000;
        ex_op1 = 32'd5; ex_op2 = 32'd3; ex_rd = 5'd4;
        @(posedge clk); #1;
        ex_func3 = F_DIV; ex_muldiv = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;

        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 3, -1, -1);
        pin("div_m7_2", 32'hFFFF_FFFD);
        chk("dvd_m7", last_dvd, 32'd7);
        chk("dvs_2", last_dvs, 32'd2);
        run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 2, -1, -1);
        pin("rem_m7_2", 32'hFFFF_FFFF);

        run_op(F_DIVU, 32'h1234_5678, 32'd0, 5'd7, 1, -1, -1);
        pin("divu_by0", 32'hFFFF_FFFF);
        run_op(F_REMU, 32'h1234_5678, 32'd0, 5'd7, 1, -1, -1);
        pin("remu_by0", 32'h1234_5678);

        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, -1, -1);
        pin("div_ovf", 32'h8000_0000);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, -1, -1);
        pin("rem_ovf", 32'h0000_0000);

        // Flush in the accept cycle blocks the accept
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_func3 = F_DIVU;
        ex_op1 = 32'd100; ex_op2 = 32'd7; flush = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b0;

        run_op(F_DIVU, 32'd100, 32'd7, 5'd9, 6, 2, -1);

        run_op(F_DIV, 32'd100, 32'd7, 5'd10, 4, -1, -1);
        pin("div_100_7", 32'd14);
        run_op(F_REM, 32'd100, 32'd7, 5'd11, 4, -1, -1);
        pin("rem_100_7", 32'd2);

        run_op(F_DIV, 32'd20, 32'hFFFF_FFFD, 5'd12, 1, -1, -1);
        pin("div_20_m3", 32'hFFFF_FFFA);
        run_op(F_REM, 32'd20, 32'hFFFF_FFFD, 5'd12, 1, -1, -1);
        pin("rem_20_m3", 32'd2);
        run_op(F_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd13, 2, -1, -1);
        pin("div_m20_m3", 32'd6);
        run_op(F_REM, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd13, 2, -1, -1);
        pin("rem_m20_m3", 32'hFFFF_FFFE);
        run_op(F_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd14, 3, -1, -1);
        pin("divu_big", 32'h7FFF_FFFC);
        chk("dvd_big", last_dvd, 32'hFFFF_FFF9);

        run_op(F_DIVU, 32'd10, 32'd3, 5'd0, 2, -1, -1);
        chk("x0_no_write", {31'd0, wd_en}, 32'd0);
        chk("x0_no_stall", {31'd0, stall_req}, 32'd0);

        run_op(F_DIV, 32'd1000, 32'd9, 5'd15, 8, -1, 3);
        chk("midrst_dvd", div_dividend, 32'd0);
        chk("midrst_dvs", div_divisor, 32'd0);
        chk("midrst_wd_data", wd_data, 32'd0);

        run_op(F_REM, 32'd100, 32'd7, 5'd16, 2, -1, -1);
        pin("rem_after_rst", 32'd2);

        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
